// File: rtl/rename_table_ckpt.sv
// Register rename table with checkpoint slots for mispredict recovery.
// Renames apply oldest-to-youngest per group; snapshots capture the post-rename map.
module rename_table_ckpt #(
  parameter int NUM_AREG = 32,
  parameter int PW       = 6,
  parameter int NPORT    = 2,
  parameter int NCKPT    = 4,
  localparam int AW      = $clog2(NUM_AREG),
  localparam int CW      = $clog2(NCKPT)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic [NPORT-1:0]       ren_valid_i,
  input  logic [NPORT*AW-1:0]    ren_areg_i,
  input  logic [NPORT*PW-1:0]    ren_preg_i,
  output logic [NPORT-1:0]       old_valid_o,
  output logic [NPORT*PW-1:0]    old_preg_o,
  output logic [NUM_AREG*PW-1:0] map_out_o,
  input  logic                   ckpt_take_i,
  output logic [CW-1:0]          ckpt_id_o,
  output logic                   ckpt_full_o,
  input  logic                   ckpt_release_i,
  input  logic                   ckpt_restore_i,
  input  logic [CW-1:0]          restore_id_i,
  input  logic                   flush_i,
  input  logic [NUM_AREG*PW-1:0] flush_map_i,
  output logic [CW:0]            ckpt_count_o,
  output logic                   restore_err_o
);

  logic [PW-1:0]       map_q   [NUM_AREG];
  logic [PW-1:0]       map_d   [NUM_AREG];
  logic [PW-1:0]       map_ren [NUM_AREG];
  logic [PW-1:0]       ckpt_q  [NCKPT][NUM_AREG];
  logic [CW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CW:0]         count_q, count_d;
  logic [NPORT-1:0]    old_valid_q, old_valid_d;
  logic [NPORT*PW-1:0] old_preg_q, old_preg_d;
  logic                err_q, err_d;
  logic [NPORT-1:0]    ren_hit;
  logic [NPORT*PW-1:0] ren_old;
  logic [CW-1:0]       rst_off;
  logic                rst_live, full, take_ok, rel_ok, ckpt_wr;

  // Sequential port walk: a younger port sees an older port's write as its prior mapping.
  always_comb begin
    map_ren = map_q;
    ren_hit = '0;
    ren_old = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (ren_valid_i[k] && (ren_areg_i[k*AW +: AW] != '0)) begin
        ren_hit[k]              = 1'b1;
        ren_old[k*PW +: PW]     = map_ren[ren_areg_i[k*AW +: AW]];
        map_ren[ren_areg_i[k*AW +: AW]] = ren_preg_i[k*PW +: PW];
      end
    end
  end

  always_comb begin
    full     = (count_q == (CW+1)'(NCKPT));
    rst_off  = restore_id_i - head_q;
    rst_live = ({1'b0, rst_off} < count_q);
    take_ok  = ckpt_take_i && (!full || ckpt_release_i);
    rel_ok   = ckpt_release_i && (count_q != '0);
  end

  always_comb begin
    map_d       = map_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    old_valid_d = '0;
    old_preg_d  = '0;
    err_d       = 1'b0;
    ckpt_wr     = 1'b0;
    if (flush_i) begin
      for (int i = 0; i < NUM_AREG; i++) map_d[i] = flush_map_i[i*PW +: PW];
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (ckpt_restore_i) begin
      // A restore consumes the whole cycle, legal or not.
      if (rst_live) begin
        map_d   = ckpt_q[restore_id_i];
        tail_d  = restore_id_i;
        count_d = {1'b0, rst_off};
      end else begin
        err_d = 1'b1;
      end
    end else begin
      map_d       = map_ren;
      old_valid_d = ren_hit;
      old_preg_d  = ren_old;
      ckpt_wr     = take_ok;
      if (take_ok) tail_d = tail_q + CW'(1);
      if (rel_ok)  head_d = head_q + CW'(1);
      count_d = count_q + {{CW{1'b0}}, take_ok} - {{CW{1'b0}}, rel_ok};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_AREG; i++) map_q[i] <= PW'(i);
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      old_valid_q <= '0;
      old_preg_q  <= '0;
      err_q       <= 1'b0;
    end else if (!stall_i) begin
      map_q       <= map_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      old_valid_q <= old_valid_d;
      old_preg_q  <= old_preg_d;
      err_q       <= err_d;
    end
  end

  // Snapshot storage carries no reset; liveness is tracked by head/count alone.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !stall_i && ckpt_wr) ckpt_q[tail_q] <= map_ren;
  end

  always_comb begin
    for (int i = 0; i < NUM_AREG; i++) map_out_o[i*PW +: PW] = map_q[i];
  end

  assign old_valid_o   = old_valid_q;
  assign old_preg_o    = old_preg_q;
  assign ckpt_id_o     = tail_q;
  assign ckpt_full_o   = full;
  assign ckpt_count_o  = count_q;
  assign restore_err_o = err_q;

endmodule

// File: tb/tb_rename_table_ckpt.sv
// Bench for rename_table_ckpt: queue-of-snapshots reference model compared every
// cycle, plus hand-computed literal checks on directed scenarios.
module tb_rename_table_ckpt;
  localparam int NUM_AREG = 32;
  localparam int PW       = 6;
  localparam int NPORT    = 2;
  localparam int NCKPT    = 4;
  localparam int AW       = 5;
  localparam int CW       = 2;

  logic                   clk, reset, stall;
  logic [NPORT-1:0]       ren_valid;
  logic [NPORT*AW-1:0]    ren_areg;
  logic [NPORT*PW-1:0]    ren_preg;
  logic [NPORT-1:0]       old_valid;
  logic [NPORT*PW-1:0]    old_preg;
  logic [NUM_AREG*PW-1:0] map_out;
  logic                   take, rel, restore, flush;
  logic [CW-1:0]          ckpt_id, restore_id;
  logic                   ckpt_full, restore_err;
  logic [NUM_AREG*PW-1:0] flush_map;
  logic [CW:0]            ckpt_count;

  rename_table_ckpt #(.NUM_AREG(NUM_AREG), .PW(PW), .NPORT(NPORT), .NCKPT(NCKPT)) dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .ren_valid_i(ren_valid), .ren_areg_i(ren_areg), .ren_preg_i(ren_preg),
    .old_valid_o(old_valid), .old_preg_o(old_preg), .map_out_o(map_out),
    .ckpt_take_i(take), .ckpt_id_o(ckpt_id), .ckpt_full_o(ckpt_full),
    .ckpt_release_i(rel), .ckpt_restore_i(restore), .restore_id_i(restore_id),
    .flush_i(flush), .flush_map_i(flush_map), .ckpt_count_o(ckpt_count),
    .restore_err_o(restore_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mapv(input int a);
    return map_out[a*PW +: PW];
  endfunction

  // Reference model: architectural map, live checkpoints as an ordered queue.
  typedef struct {
    int                     id;
    logic [NUM_AREG*PW-1:0] snap;
  } ck_t;

  ck_t  q[$];
  int   mm[NUM_AREG];
  int   m_tail;
  bit   m_ov[NPORT];
  int   m_op[NPORT];
  bit   m_err;

  function automatic logic [NUM_AREG*PW-1:0] pack_map();
    logic [NUM_AREG*PW-1:0] r;
    for (int i = 0; i < NUM_AREG; i++) r[i*PW +: PW] = PW'(mm[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) mm[i] = i;
      q.delete();
      m_tail = 0;
      for (int k = 0; k < NPORT; k++) begin m_ov[k] = 0; m_op[k] = 0; end
      m_err = 0;
    end else if (!stall) begin
      for (int k = 0; k < NPORT; k++) begin m_ov[k] = 0; m_op[k] = 0; end
      m_err = 0;
      if (flush) begin
        for (int i = 0; i < NUM_AREG; i++) mm[i] = int'(flush_map[i*PW +: PW]);
        q.delete();
        m_tail = 0;
      end else if (restore) begin
        int p;
        p = -1;
        for (int j = 0; j < q.size(); j++) if (q[j].id == int'(restore_id)) p = j;
        if (p >= 0) begin
          for (int i = 0; i < NUM_AREG; i++) mm[i] = int'(q[p].snap[i*PW +: PW]);
          while (q.size() > p) void'(q.pop_back());
          m_tail = int'(restore_id);
        end else begin
          m_err = 1;
        end
      end else begin
        bit can_take;
        ck_t c;
        for (int k = 0; k < NPORT; k++) begin
          int a;
          a = int'(ren_areg[k*AW +: AW]);
          if (ren_valid[k] && a != 0) begin
            m_ov[k] = 1;
            m_op[k] = mm[a];
            mm[a]   = int'(ren_preg[k*PW +: PW]);
          end
        end
        can_take = take && (q.size() < NCKPT || rel);
        if (rel && q.size() > 0) void'(q.pop_front());
        if (can_take) begin
          c.id   = m_tail;
          c.snap = pack_map();
          q.push_back(c);
          m_tail = (m_tail + 1) % NCKPT;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NPORT-1:0]    e_ov;
      logic [NPORT*PW-1:0] e_op;
      for (int k = 0; k < NPORT; k++) begin
        e_ov[k]         = m_ov[k];
        e_op[k*PW +: PW] = PW'(m_op[k]);
      end
      chk("m_map", map_out, pack_map());
      chk("m_old_valid", old_valid, e_ov);
      chk("m_old_preg", old_preg, e_op);
      chk("m_count", ckpt_count, q.size());
      chk("m_ckpt_id", ckpt_id, m_tail);
      chk("m_full", ckpt_full, q.size() == NCKPT);
      chk("m_restore_err", restore_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; ren_valid = '0; ren_areg = '0; ren_preg = '0;
    take = 0; rel = 0; restore = 0; restore_id = '0; flush = 0;
  endtask

  task automatic ren(input int k, input int a, input int p);
    ren_valid[k]         = 1'b1;
    ren_areg[k*AW +: AW] = AW'(a);
    ren_preg[k*PW +: PW] = PW'(p);
  endtask

  initial begin
    for (int i = 0; i < NUM_AREG; i++) flush_map[i*PW +: PW] = PW'((i * 3 + 1) % 64);
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk_en = 1;
    chk("rst_map5", mapv(5), 5);
    chk("rst_count", ckpt_count, 0);
    chk("rst_old_valid", old_valid, 0);
    chk("rst_full", ckpt_full, 0);

    idle(); ren(0, 5, 40); tick();
    chk("single_ov", old_valid, 2'b01);
    chk("single_op0", old_preg[5:0], 5);
    chk("single_map5", mapv(5), 40);

    idle(); ren(0, 3, 33); ren(1, 3, 34); tick();
    chk("haz_op0", old_preg[5:0], 3);
    chk("haz_op1", old_preg[11:6], 33);
    chk("haz_map3", mapv(3), 34);

    idle(); ren(0, 0, 9); tick();
    chk("a0_ov", old_valid, 0);
    chk("a0_map0", mapv(0), 0);

    idle(); ren(0, 7, 50); take = 1; tick();
    chk("ck_id1", ckpt_id, 1);
    chk("ck_cnt1", ckpt_count, 1);
    idle(); ren(0, 7, 51); take = 1; tick();
    chk("ck_cnt2", ckpt_count, 2);
    idle(); ren(0, 7, 52); tick();
    chk("ck_map7_52", mapv(7), 52);
    chk("ck_op0_51", old_preg[5:0], 51);
    idle(); restore = 1; restore_id = 0; tick();
    chk("rs_map7", mapv(7), 50);
    chk("rs_cnt", ckpt_count, 0);
    chk("rs_id", ckpt_id, 0);
    chk("rs_ov", old_valid, 0);

    for (int i = 0; i < 4; i++) begin
      idle(); ren(0, 9, 20 + i); take = 1; tick();
    end
    chk("full_flag", ckpt_full, 1);
    chk("full_cnt", ckpt_count, 4);
    chk("full_id", ckpt_id, 0);
    idle(); ren(0, 9, 24); take = 1; tick();
    chk("drop_cnt", ckpt_count, 4);
    chk("drop_id", ckpt_id, 0);
    idle(); ren(0, 9, 25); take = 1; rel = 1; tick();
    chk("wrap_cnt", ckpt_count, 4);
    chk("wrap_id", ckpt_id, 1);
    idle(); restore = 1; restore_id = 2; tick();
    chk("mid_cnt", ckpt_count, 1);
    chk("mid_id", ckpt_id, 2);
    chk("mid_map9", mapv(9), 22);

    idle(); rel = 1; tick();
    chk("rel_cnt0", ckpt_count, 0);
    idle(); restore = 1; restore_id = 2; tick();
    chk("bad_err", restore_err, 1);
    chk("bad_map9", mapv(9), 22);
    idle(); tick();
    chk("bad_err_clr", restore_err, 0);

    idle(); ren(0, 4, 44); take = 1; tick();
    chk("pre_op0", old_preg[5:0], 4);
    chk("pre_cnt", ckpt_count, 1);
    idle(); stall = 1; flush = 1; ren(0, 4, 45); tick(); tick();
    chk("stall_map4", mapv(4), 44);
    chk("stall_op0", old_preg[5:0], 4);
    chk("stall_ov", old_valid, 2'b01);
    stall = 0; tick();
    chk("flush_map4", mapv(4), 13);
    chk("flush_cnt", ckpt_count, 0);
    chk("flush_ov", old_valid, 0);

    idle(); take = 1; tick();
    chk("pre_rst_cnt", ckpt_count, 1);
    idle(); reset = 1; stall = 1; tick();
    reset = 0; stall = 0;
    chk("midrst_cnt", ckpt_count, 0);
    chk("midrst_map4", mapv(4), 4);
    idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
